wb_register_file: RTL and testbench
===================================

# wb_register_file

Writeback-stage consumer of the MEM/WB pipeline bundle: selects the writeback value (ALU/FPU result or load data), commits it into a unified 64-entry register file (32 integer + 32 floating-point registers, 6-bit address), and serves the ID stage's read ports with same-cycle write bypass. It also keeps a registered last-commit record and a commit counter for the Nexys3 debug display.

## Interface
Parameters:
- DATA_W, 32, register and data width
- ADDR_W, 6, register address width; bit 5 set = FP register file half
- NUM_REGS, 64, register count (2**ADDR_W)
- CNT_W, 16, commit counter width

Ports:
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- wb_ctrl  in  2  bit1 = RegWrite, bit0 = MemtoReg
- wb_alu_result  in  DATA_W  ALU/FPU result from MEM/WB
- wb_mem_data  in  DATA_W  load data from MEM/WB
- wb_write_address  in  ADDR_W  destination register
- rs_addr, rt_addr  in  ADDR_W  ID-stage read addresses
- rs_data, rt_data  out  DATA_W  ID-stage read data
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  debug read data (no bypass)
- wb_value  out  DATA_W  combinational selected writeback value (for EX forwarding)
- last_addr  out  ADDR_W  registered address of most recent commit
- last_data  out  DATA_W  registered data of most recent commit
- commit_count  out  CNT_W  number of commits since reset

## Operation
- wb_value = wb_ctrl[0] ? wb_mem_data : wb_alu_result.
- Commit occurs on a clock edge when wb_ctrl[1]=1 and wb_write_address != 0.
- Address 0 (integer $zero) is hardwired to 0: writes discarded, no commit counted, reads return 0. Address 32 (FP f0) is an ordinary writable register.
- Commit: regs[wb_write_address] <= wb_value; last_addr/last_data updated; commit_count += 1, wrapping from 2**CNT_W-1 to 0.
- Read ports rs/rt: if a commit is pending this cycle and the read address equals wb_write_address, return wb_value (bypass); otherwise return regs[addr]; address 0 always 0.
- Both rs and rt may bypass at once. dbg_data reads stored state only.
- wb_ctrl[1]=0: no state changes regardless of other inputs.

## Timing
- Reset (reset=0, asynchronous): all 64 registers, last_addr, last_data, commit_count = 0. Combinational outputs then reflect zeroed state.
- Write latency: 1 edge; stored value visible on dbg_data the cycle after the commit edge.
- Read latency: 0 (combinational) for rs/rt/dbg/wb_value.
- Bypass covers the cycle before the edge, so the ID stage reading the WB destination in the same cycle gets the new value (no extra stall).
- Reset asserted mid-cycle with a pending commit: commit lost, state zero; first commit possible on first rising edge after reset deasserts.
- Back-to-back commits to the same address: each edge overwrites; count increments each edge.

## Structure
- Shared package/include: WB_REGWRITE_BIT=1, WB_MEMTOREG_BIT=0, REG_ZERO=6'd0, FP_BASE=6'd32, DATA_W/ADDR_W defaults. MEM_WB register and hazard/forwarding units use the same constants.
- One sub-module is natural: wb_mux (2:1 writeback select producing wb_value). Register array, bypass compare and counters live in the top.

## Test plan
- Reset: drive reset=0 after writing regs 5 and 40 -> all reads 0, commit_count=0, last_addr=0 immediately (no clock edge).
- ALU commit: wb_ctrl=2'b10, alu=0x0000_1234, addr=5 -> after edge dbg_data(5)=0x1234, last_addr=5, commit_count=1; during the cycle rs_addr=5 reads 0x1234 via bypass.
- Load commit to FP: wb_ctrl=2'b11, mem=0x3F80_0000, alu=0xDEAD_BEEF, addr=33 -> reg33=0x3F80_0000; rs_addr=rt_addr=33 both bypass 0x3F80_0000.
- $zero: wb_ctrl=2'b10, alu=0xFFFF_FFFF, addr=0 -> reg0 reads 0, commit_count unchanged; same with addr=32 -> reg32=0xFFFF_FFFF, count+1.
- RegWrite low: wb_ctrl=2'b01, addr=7, mem=0xAAAA_AAAA -> reg7 unchanged, no bypass on rs_addr=7, count unchanged.
- Counter wrap: preload via 65535 commits -> next commit gives commit_count=0.

Source files
------------

// File: rtl/wb_register_file_pkg.sv
// Shared writeback-stage constants: control bit positions, special register
// addresses and default widths, common to MEM/WB, hazard and forwarding logic.
// Ports: none (package).
package wb_register_file_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 6;

  // Bit positions inside the 2-bit MEM/WB writeback control field.
  localparam int WB_REGWRITE_BIT = 1;
  localparam int WB_MEMTOREG_BIT = 0;

  // Integer $zero is hardwired; FP f0 (first register of the upper half) is not.
  localparam logic [5:0] REG_ZERO = 6'd0;
  localparam logic [5:0] FP_BASE  = 6'd32;

endpackage

// File: rtl/wb_mux.sv
// Writeback value select: load data when MemtoReg is set, else ALU/FPU result.
// Latency: 0 (purely combinational). Backpressure: none, follows its inputs.
// Ports: mem_to_reg (select), alu_result, mem_data (DATA_W in), wb_value (DATA_W out).
module wb_mux #(
  parameter int DATA_W = 32
) (
  input  logic              mem_to_reg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] wb_value
);

  assign wb_value = mem_to_reg ? mem_data : alu_result;

endmodule

// File: rtl/wb_register_file.sv
// Writeback stage: selects the writeback value, commits it into a unified
// 64-entry int/FP register file and serves ID read ports with same-cycle bypass.
// Latency: writes land on the next rising edge; all reads are combinational.
// Backpressure: none; a commit is accepted every cycle RegWrite is set.
// Ports: clk, reset (async active-low); wb_ctrl/wb_alu_result/wb_mem_data/
// wb_write_address from MEM/WB; rs/rt addr->data for ID; dbg addr->data;
// wb_value for EX forwarding; last_addr/last_data/commit_count debug record.
module wb_register_file
  import wb_register_file_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int NUM_REGS = 2 ** ADDR_W,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        wb_ctrl,
  input  logic [DATA_W-1:0] wb_alu_result,
  input  logic [DATA_W-1:0] wb_mem_data,
  input  logic [ADDR_W-1:0] wb_write_address,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [DATA_W-1:0] wb_value,
  output logic [ADDR_W-1:0] last_addr,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  commit_count
);

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              commit;

  wb_mux #(.DATA_W(DATA_W)) u_wb_mux (
    .mem_to_reg (wb_ctrl[WB_MEMTOREG_BIT]),
    .alu_result (wb_alu_result),
    .mem_data   (wb_mem_data),
    .wb_value   (wb_value)
  );

  // Gated by reset so that while reset is held the bypass path cannot expose
  // a commit that will never happen; reads then reflect the zeroed array.
  assign commit = reset && wb_ctrl[WB_REGWRITE_BIT] && (wb_write_address != ZERO_ADDR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      last_addr    <= '0;
      last_data    <= '0;
      commit_count <= '0;
    end else if (commit) begin
      regs[wb_write_address] <= wb_value;
      last_addr              <= wb_write_address;
      last_data              <= wb_value;
      commit_count           <= commit_count + CNT_W'(1);
    end
  end

  // Same-cycle bypass lets ID read the WB destination without a stall.
  always_comb begin
    rs_data = regs[rs_addr];
    if (rs_addr == ZERO_ADDR) begin
      rs_data = '0;
    end else if (commit && (rs_addr == wb_write_address)) begin
      rs_data = wb_value;
    end
  end

  always_comb begin
    rt_data = regs[rt_addr];
    if (rt_addr == ZERO_ADDR) begin
      rt_data = '0;
    end else if (commit && (rt_addr == wb_write_address)) begin
      rt_data = wb_value;
    end
  end

  // Debug port shows architectural state only, never the in-flight value.
  always_comb begin
    dbg_data = regs[dbg_addr];
    if (dbg_addr == ZERO_ADDR) begin
      dbg_data = '0;
    end
  end

endmodule

// File: tb/tb_wb_register_file.sv
// Scoreboard bench for wb_register_file: directed stimulus pushes expected
// values; a negedge monitor pops and compares against the DUT outputs.
module tb_wb_register_file;

  localparam int K_RS = 0, K_RT = 1, K_DBG = 2, K_WBV = 3,
                 K_LADDR = 4, K_LDATA = 5, K_CNT = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  wb_ctrl;
  logic [31:0] wb_alu_result, wb_mem_data;
  logic [5:0]  wb_write_address, rs_addr, rt_addr, dbg_addr;
  logic [31:0] rs_data, rt_data, dbg_data, wb_value, last_data;
  logic [5:0]  last_addr;
  logic [15:0] commit_count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          exp_cnt = 0;

  int          q_kind[$];
  logic [31:0] q_val[$];
  string       q_name[$];

  always #5 clk = ~clk;

  wb_register_file dut (
    .clk              (clk),
    .reset            (reset),
    .wb_ctrl          (wb_ctrl),
    .wb_alu_result    (wb_alu_result),
    .wb_mem_data      (wb_mem_data),
    .wb_write_address (wb_write_address),
    .rs_addr          (rs_addr),
    .rt_addr          (rt_addr),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .dbg_addr         (dbg_addr),
    .dbg_data         (dbg_data),
    .wb_value         (wb_value),
    .last_addr        (last_addr),
    .last_data        (last_data),
    .commit_count     (commit_count)
  );

  // Monitor: every pending expectation is compared on the falling edge,
  // mid-way between the input change (posedge+1) and the next rising edge.
  always @(negedge clk) begin
    while (q_kind.size() > 0) begin
      int          k;
      logic [31:0] e, a;
      string       nm;
      k  = q_kind.pop_front();
      e  = q_val.pop_front();
      nm = q_name.pop_front();
      case (k)
        K_RS:    a = rs_data;
        K_RT:    a = rt_data;
        K_DBG:   a = dbg_data;
        K_WBV:   a = wb_value;
        K_LADDR: a = {26'd0, last_addr};
        K_LDATA: a = last_data;
        default: a = {16'd0, commit_count};
      endcase
      n_cmp++;
      if (a !== e) begin
        n_bad++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", nm, a, e);
      end
    end
  end

  task automatic expect_val(input int k, input logic [31:0] v, input string nm);
    q_kind.push_back(k);
    q_val.push_back(v);
    q_name.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ctrl, input logic [31:0] alu,
                       input logic [31:0] mem, input logic [5:0] addr);
    wb_ctrl          = ctrl;
    wb_alu_result    = alu;
    wb_mem_data      = mem;
    wb_write_address = addr;
  endtask

  // One committed write followed by an idle slot.
  task automatic commit_one(input logic [5:0] addr, input logic [31:0] v);
    drive(2'b10, v, 32'h0, addr);
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    exp_cnt = (exp_cnt + 1) % 65536;
  endtask

  initial begin
    reset = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    rs_addr = 6'd0; rt_addr = 6'd0; dbg_addr = 6'd0;
    #2;
    expect_val(K_CNT,   32'd0, "por_count");
    expect_val(K_LADDR, 32'd0, "por_last_addr");
    tick();
    reset = 1'b1;
    tick();

    // Populate regs 5 and 40, then reset asynchronously without any edge.
    commit_one(6'd5,  32'h0000_0011);
    commit_one(6'd40, 32'h0000_0022);
    dbg_addr = 6'd40;
    expect_val(K_DBG, 32'h0000_0022, "pre_reset_r40");
    expect_val(K_CNT, 32'd2,         "pre_reset_count");
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    rs_addr = 6'd5; rt_addr = 6'd40; dbg_addr = 6'd40;
    #1;
    expect_val(K_RS,    32'd0, "rst_rs5");
    expect_val(K_RT,    32'd0, "rst_rt40");
    expect_val(K_DBG,   32'd0, "rst_dbg40");
    expect_val(K_CNT,   32'd0, "rst_count");
    expect_val(K_LADDR, 32'd0, "rst_last_addr");
    expect_val(K_LDATA, 32'd0, "rst_last_data");
    tick();
    reset = 1'b1;
    tick();

    // ALU commit with same-cycle bypass on rs.
    drive(2'b10, 32'h0000_1234, 32'h5555_5555, 6'd5);
    rs_addr = 6'd5; rt_addr = 6'd6;
    expect_val(K_WBV, 32'h0000_1234, "alu_wb_value");
    expect_val(K_RS,  32'h0000_1234, "alu_bypass_rs");
    expect_val(K_RT,  32'h0000_0000, "alu_no_bypass_rt");
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    exp_cnt = 1;
    dbg_addr = 6'd5;
    expect_val(K_DBG,   32'h0000_1234, "alu_dbg5");
    expect_val(K_LADDR, 32'd5,         "alu_last_addr");
    expect_val(K_LDATA, 32'h0000_1234, "alu_last_data");
    expect_val(K_CNT,   32'd1,         "alu_count");
    tick();

    // Load into FP register 33; both read ports bypass.
    drive(2'b11, 32'hDEAD_BEEF, 32'h3F80_0000, 6'd33);
    rs_addr = 6'd33; rt_addr = 6'd33;
    expect_val(K_WBV, 32'h3F80_0000, "ld_wb_value");
    expect_val(K_RS,  32'h3F80_0000, "ld_bypass_rs");
    expect_val(K_RT,  32'h3F80_0000, "ld_bypass_rt");
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    exp_cnt = 2;
    dbg_addr = 6'd33;
    expect_val(K_DBG,   32'h3F80_0000, "ld_dbg33");
    expect_val(K_LADDR, 32'd33,        "ld_last_addr");
    expect_val(K_CNT,   32'd2,         "ld_count");
    tick();

    // Write to $zero: discarded, not bypassed, not counted.
    drive(2'b10, 32'hFFFF_FFFF, 32'h0, 6'd0);
    rs_addr = 6'd0;
    expect_val(K_RS,  32'h0,         "zero_rs_no_bypass");
    expect_val(K_WBV, 32'hFFFF_FFFF, "zero_wb_value");
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    dbg_addr = 6'd0;
    expect_val(K_DBG,   32'h0,         "zero_dbg0");
    expect_val(K_CNT,   32'd2,         "zero_count");
    expect_val(K_LADDR, 32'd33,        "zero_last_addr");
    expect_val(K_LDATA, 32'h3F80_0000, "zero_last_data");
    tick();

    // f0 (address 32) is an ordinary register.
    drive(2'b10, 32'hFFFF_FFFF, 32'h0, 6'd32);
    rs_addr = 6'd32;
    expect_val(K_RS, 32'hFFFF_FFFF, "f0_bypass_rs");
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    exp_cnt = 3;
    dbg_addr = 6'd32;
    expect_val(K_DBG,   32'hFFFF_FFFF, "f0_dbg32");
    expect_val(K_CNT,   32'd3,         "f0_count");
    expect_val(K_LADDR, 32'd32,        "f0_last_addr");
    tick();

    // RegWrite low: no commit, no bypass.
    commit_one(6'd7, 32'h0000_0077);
    drive(2'b01, 32'h0, 32'hAAAA_AAAA, 6'd7);
    rs_addr = 6'd7;
    expect_val(K_WBV, 32'hAAAA_AAAA, "rwlow_wb_value");
    expect_val(K_RS,  32'h0000_0077, "rwlow_rs_no_bypass");
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    dbg_addr = 6'd7;
    expect_val(K_DBG,   32'h0000_0077, "rwlow_dbg7");
    expect_val(K_CNT,   32'd4,         "rwlow_count");
    expect_val(K_LADDR, 32'd7,         "rwlow_last_addr");
    tick();

    // Back-to-back commits to the same register.
    drive(2'b10, 32'h0000_0001, 32'h0, 6'd9);
    tick();
    drive(2'b10, 32'h0000_0002, 32'h0, 6'd9);
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    exp_cnt = 6;
    dbg_addr = 6'd9;
    expect_val(K_DBG, 32'h0000_0002, "b2b_dbg9");
    expect_val(K_CNT, 32'd6,         "b2b_count");
    tick();

    // Reset mid-cycle with a commit pending: the commit is lost.
    drive(2'b10, 32'h0000_0099, 32'h0, 6'd9);
    reset = 1'b0;
    tick();
    dbg_addr = 6'd9;
    expect_val(K_DBG, 32'h0, "midrst_dbg9");
    expect_val(K_CNT, 32'd0, "midrst_count");
    tick();
    // First edge after release commits.
    reset = 1'b1;
    drive(2'b10, 32'h0000_00A0, 32'h0, 6'd10);
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    exp_cnt = 1;
    dbg_addr = 6'd10;
    expect_val(K_DBG, 32'h0000_00A0, "postrst_dbg10");
    expect_val(K_CNT, 32'd1,         "postrst_count");
    tick();

    // Drive the counter to its maximum, then wrap.
    drive(2'b10, 32'h0, 32'h0, 6'd3);
    while (exp_cnt != 65535) begin
      wb_alu_result = exp_cnt;
      tick();
      exp_cnt++;
    end
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    expect_val(K_CNT,   32'd65535, "wrap_max_count");
    expect_val(K_LDATA, 32'd65534, "wrap_max_last_data");
    tick();
    drive(2'b10, 32'h0000_BEEF, 32'h0, 6'd3);
    tick();
    drive(2'b00, 32'h0, 32'h0, 6'd0);
    dbg_addr = 6'd3;
    expect_val(K_CNT,   32'd0,         "wrap_count");
    expect_val(K_LADDR, 32'd3,         "wrap_last_addr");
    expect_val(K_DBG,   32'h0000_BEEF, "wrap_dbg3");
    tick();

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && q_kind.size() > 0; i++) tick();
    if (q_kind.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q_kind.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
